adap_thresh_3x3: RTL and testbench

- Local-mean adaptive binarisation stage. It sits directly downstream of the image source / sync generator.
- Consumes the streamed greyscale pixels with their hsync/vsync/de.
- Builds a 3x3 neighbourhood from two line buffers and compares the centre pixel against the window mean minus an offset.
- Emits a binary (0/255) pixel stream with hsync/vsync/de delayed to match, ready for display or further morphology.

---
 rtl/adap_thresh_pkg.sv | 24 ++
 rtl/line_buf_dp.sv | 23 ++
 rtl/adap_thresh_3x3.sv | 164 ++++++++++++++++
 tb/tb_adap_thresh_3x3.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/adap_thresh_pkg.sv
// Shared widths, pixel constants and the divider-free threshold test
// for the 3x3 local-mean binarisation stage.
package adap_thresh_pkg;

    localparam int PIX_W    = 8;
    localparam int SUM_W    = 12;
    localparam int CMP_W    = 13;
    localparam int PIPE_LAT = 4;

    localparam logic [PIX_W-1:0] WHITE = 8'd255;
    localparam logic [PIX_W-1:0] BLACK = 8'd0;

    // centre > sum/9 - offset, rearranged to avoid the divide
    function automatic logic is_white(
        input logic [PIX_W-1:0] centre,
        input logic [PIX_W-1:0] offset,
        input logic [SUM_W-1:0] sum
    );
        logic [CMP_W-1:0] scaled;
        scaled = CMP_W'(9) * (CMP_W'(centre) + CMP_W'(offset));
        return scaled > CMP_W'(sum);
    endfunction

endpackage

// File: rtl/line_buf_dp.sv
// Simple dual-port line RAM: one write port, one registered read port.
// A same-address read and write returns the old contents.
module line_buf_dp #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/adap_thresh_3x3.sv
// 3x3 local-mean adaptive binarisation with two line buffers.
// Fixed 4-clock latency; syncs and de ride a matching delay line.
module adap_thresh_3x3
    import adap_thresh_pkg::*;
#(
    parameter int               H_DISP = 640,
    parameter int               V_DISP = 480,
    parameter logic [PIX_W-1:0] OFFSET = 8'd5,
    parameter int               ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             img_hsync,
    input  logic             img_vsync,
    input  logic [PIX_W-1:0] img_data,
    input  logic             img_de,
    output logic             seg_hsync,
    output logic             seg_vsync,
    output logic [PIX_W-1:0] seg_data,
    output logic             seg_de
);

    localparam int                ROW_W   = $clog2(V_DISP + 1);
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(H_DISP - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(V_DISP);
    localparam logic [ADDR_W-1:0] COL_TWO = ADDR_W'(2);
    localparam logic [ROW_W-1:0]  ROW_TWO = ROW_W'(2);

    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    logic              de_q;
    logic              vs_q;
    logic              synced;

    // Row stays 0 after a reset until a vsync edge re-aligns the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            de_q   <= 1'b0;
            vs_q   <= 1'b0;
            synced <= 1'b0;
        end else begin
            de_q <= img_de;
            vs_q <= img_vsync;
            if (img_de) begin
                if (col != COL_MAX) col <= col + 1'b1;
            end else if (de_q) begin
                col <= '0;
            end
            if (vs_q && !img_vsync) begin
                row    <= '0;
                synced <= 1'b1;
            end else if (de_q && !img_de && synced && row != ROW_MAX) begin
                row <= row + 1'b1;
            end
        end
    end

    logic [PIX_W-1:0]  lb1_q;
    logic [PIX_W-1:0]  lb2_q;
    logic [PIX_W-1:0]  pix_d1;
    logic [ADDR_W-1:0] col_d1;
    logic              de_d1;
    logic              bord_d1;

    line_buf_dp #(.DEPTH(H_DISP), .ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (img_de),
        .waddr (col),
        .wdata (img_data),
        .raddr (col),
        .rdata (lb1_q)
    );

    // lb2 takes lb1's old contents one clock later, at the same column
    line_buf_dp #(.DEPTH(H_DISP), .ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_lb2 (
        .clk   (clk),
        .we    (de_d1),
        .waddr (col_d1),
        .wdata (lb1_q),
        .raddr (col),
        .rdata (lb2_q)
    );

    logic [PIX_W-1:0] win [3][3];
    logic             de_d2;
    logic             bord_d2;
    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] sum_d3;
    logic [PIX_W-1:0] ctr_d3;
    logic             de_d3;
    logic             bord_d3;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                sum_c = sum_c + SUM_W'(win[i][j]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_d1  <= '0;
            col_d1  <= '0;
            de_d1   <= 1'b0;
            bord_d1 <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
            de_d2    <= 1'b0;
            bord_d2  <= 1'b0;
            sum_d3   <= '0;
            ctr_d3   <= '0;
            de_d3    <= 1'b0;
            bord_d3  <= 1'b0;
            seg_data <= BLACK;
            seg_de   <= 1'b0;
        end else begin
            pix_d1  <= img_data;
            col_d1  <= col;
            de_d1   <= img_de;
            bord_d1 <= (row < ROW_TWO) || (col < COL_TWO);

            if (de_d1) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_q;
                win[1][2] <= lb1_q;
                win[2][2] <= pix_d1;
            end
            de_d2   <= de_d1;
            bord_d2 <= bord_d1;

            sum_d3  <= sum_c;
            ctr_d3  <= win[1][1];
            de_d3   <= de_d2;
            bord_d3 <= bord_d2;

            seg_de   <= de_d3;
            seg_data <= (de_d3 && !bord_d3 && is_white(ctr_d3, OFFSET, sum_d3))
                        ? WHITE : BLACK;
        end
    end

    logic [PIPE_LAT-1:0] hs_sr;
    logic [PIPE_LAT-1:0] vs_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_sr <= '1;
            vs_sr <= '1;
        end else begin
            hs_sr <= {hs_sr[PIPE_LAT-2:0], img_hsync};
            vs_sr <= {vs_sr[PIPE_LAT-2:0], img_vsync};
        end
    end

    assign seg_hsync = hs_sr[PIPE_LAT-1];
    assign seg_vsync = vs_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_adap_thresh_3x3.sv
// Scoreboard bench for adap_thresh_3x3 on a reduced 20x10 raster:
// flat, single-spot and random frames, plus an asynchronous mid-frame reset.
module tb_adap_thresh_3x3;

    localparam int         H   = 20;
    localparam int         V   = 10;
    localparam logic [7:0] OFF = 8'd5;
    localparam int         HS  = 3;
    localparam int         HB  = 3;
    localparam int         HT  = HS + HB + H + 2;
    localparam int         VS  = 2;
    localparam int         VB  = 2;
    localparam int         VT  = VS + VB + V + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       img_hsync = 1'b1;
    logic       img_vsync = 1'b1;
    logic [7:0] img_data = 8'd0;
    logic       img_de = 1'b0;
    logic       seg_hsync;
    logic       seg_vsync;
    logic [7:0] seg_data;
    logic       seg_de;

    always #5 clk = ~clk;

    adap_thresh_3x3 #(
        .H_DISP (H),
        .V_DISP (V),
        .OFFSET (OFF),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .img_hsync (img_hsync),
        .img_vsync (img_vsync),
        .img_data  (img_data),
        .img_de    (img_de),
        .seg_hsync (seg_hsync),
        .seg_vsync (seg_vsync),
        .seg_data  (seg_data),
        .seg_de    (seg_de)
    );

    int         checks = 0;
    int         failures = 0;
    int         n_exp = 0;
    int         n_seen = 0;
    logic [7:0] exp_q [$];
    logic [7:0] img [V][H];
    bit         blackout = 1'b0;
    logic [2:0] hist [4];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Output for input position (r,c): centre (r-1,c-1) vs mean of its 3x3
    function automatic logic [7:0] ref_pix(input int r, input int c);
        int  sum;
        int  ctr;
        real mean;
        if (r < 2 || c < 2) return 8'd0;
        sum = 0;
        for (int dr = -2; dr <= 0; dr++)
            for (int dc = -2; dc <= 0; dc++)
                sum += int'(img[r+dr][c+dc]);
        ctr  = int'(img[r-1][c-1]);
        mean = real'(sum) / 9.0;
        return (real'(ctr) > mean - real'(OFF)) ? 8'd255 : 8'd0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] = 3'b110;
        end else begin
            chk("sync_delay", int'({seg_hsync, seg_vsync, seg_de}), int'(hist[3]));
            if (seg_de) begin
                n_seen++;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    chk("seg_data", int'(seg_data), int'(exp_q.pop_front()));
                end
            end else begin
                chk("seg_data_idle", int'(seg_data), 0);
            end
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {img_hsync, img_vsync, img_de};
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_de"}, int'(seg_de), 0);
        chk({tag, "_data"}, int'(seg_data), 0);
        chk({tag, "_hsync"}, int'(seg_hsync), 1);
        chk({tag, "_vsync"}, int'(seg_vsync), 1);
    endtask

    task automatic run_frame(input int kind, input int rst_line);
        int  r;
        int  c;
        bit  act;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                case (kind)
                    0:       img[y][x] = 8'd100;
                    1:       img[y][x] = (y == 3 && x == 3) ? 8'd200 : 8'd50;
                    default: img[y][x] = 8'($urandom_range(255));
                endcase
        for (int l = 0; l < VT; l++) begin
            for (int x = 0; x < HT; x++) begin
                @(posedge clk);
                #1;
                if (rst) rst = 1'b0;
                if (l == 0 && x == 0) blackout = 1'b0;
                act       = (l >= VS + VB) && (l < VS + VB + V);
                r         = l - VS - VB;
                c         = x - HS - HB;
                img_vsync = (l >= VS);
                img_hsync = (x >= HS);
                img_de    = act && (c >= 0) && (c < H);
                img_data  = 8'd0;
                if (img_de) begin
                    img_data = img[r][c];
                    exp_q.push_back(blackout ? 8'd0 : ref_pix(r, c));
                    n_exp++;
                end
                if (act && r == rst_line && x == 10) begin
                    #2 rst = 1'b1;
                    #1 check_reset_state("midframe_rst");
                    n_exp -= exp_q.size();
                    exp_q.delete();
                    blackout = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = 3'b110;
        repeat (3) @(posedge clk);
        #1 check_reset_state("reset");
        rst = 1'b0;
        repeat (8) @(posedge clk);
        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, 4);
        run_frame(2, -1);
        run_frame(2, -1);
        @(posedge clk);
        #1;
        img_hsync = 1'b1;
        img_vsync = 1'b1;
        img_de    = 1'b0;
        img_data  = 8'd0;
        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_left", exp_q.size(), 0);
        chk("seg_de_count", n_seen, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
